// File: rtl/pc_interrupt_sequencer_pkg.sv
// Shared types and helpers for the PC interrupt sequencer.
// Holds the state enum, vector defaults, vector math and depth-width rule.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SAVE = 2'd2
  } state_t;

  localparam int unsigned DEF_VEC_BASE   = 4;
  localparam int unsigned DEF_VEC_STRIDE = 4;

`ifdef IRQ_NESTING_EN
  localparam bit NESTING = 1'b1;
`else
  localparam bit NESTING = 1'b0;
`endif

  function automatic int unsigned nd_width(
    int unsigned depth
  );
    return NESTING ? $clog2(depth + 1) : 1;
  endfunction

  function automatic logic [31:0] vec_addr(
    int unsigned base,
    int unsigned stride,
    int unsigned idx
  );
    return 32'(base + idx * stride);
  endfunction

endpackage

// File: rtl/pc_interrupt_sequencer_if.sv
// Bundle of request/decoder inputs and PC-control outputs of the sequencer.
// slave: the sequencer; master: the surrounding logic (or a bench).
interface pc_interrupt_sequencer_if #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned NEST_DEPTH = 3
) ();
  import pc_seq_pkg::*;

  localparam int unsigned ND_W = nd_width(NEST_DEPTH);

  logic [NUM_IRQ-1:0] irq_req;
  logic               irq_mask_we;
  logic [NUM_IRQ-1:0] irq_mask_wdata;
  logic               skip;
  logic               reti;
  logic               pc_interrupt;
  logic [ADDR_W-1:0]  vector_addr;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [NUM_IRQ-1:0] in_service;
  logic [ND_W-1:0]    nest_depth;
  logic               busy;
  logic               nest_error;

  modport slave (
    input  irq_req, irq_mask_we,
    input  irq_mask_wdata, skip, reti,
    output pc_interrupt, vector_addr,
    output irq_ack, in_service,
    output nest_depth, busy, nest_error
  );

  modport master (
    output irq_req, irq_mask_we,
    output irq_mask_wdata, skip, reti,
    input  pc_interrupt, vector_addr,
    input  irq_ack, in_service,
    input  nest_depth, busy, nest_error
  );

endinterface

// File: rtl/pc_interrupt_sequencer_irq_priority_encoder.sv
// Fixed-priority encoder: index of the lowest set bit.
// Ports: vec in, valid out (any bit set), idx out.
module irq_priority_encoder #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pc_interrupt_sequencer.sv
// Fixed-priority interrupt sequencer feeding the PC control (IDLE/WAIT/SAVE).
// Ports: clk, reset (async, active-low), bus (slave). Nesting: IRQ_NESTING_EN.
module pc_interrupt_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned VEC_BASE   = DEF_VEC_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE,
  parameter int unsigned NEST_DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  pc_interrupt_sequencer_if.slave bus
);

  localparam int unsigned IW =
    (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned ND_W = nd_width(NEST_DEPTH);

  state_t             state, state_nx;
  logic [NUM_IRQ-1:0] mask, in_svc, ack_q;
  logic [NUM_IRQ-1:0] blocked, eligible, svc_clr;
  logic [IW-1:0]      idx, win_idx, low_idx, sel_idx;
  logic               win_vld, low_vld, reti_ok;
  logic [ND_W-1:0]    depth;
  logic [ADDR_W-1:0]  vaddr;
  logic               pc_int, err;

  irq_priority_encoder #(.N(NUM_IRQ), .IW(IW)) u_win (
    .vec   (eligible),
    .valid (win_vld),
    .idx   (win_idx)
  );

  irq_priority_encoder #(.N(NUM_IRQ), .IW(IW)) u_low (
    .vec   (in_svc),
    .valid (low_vld),
    .idx   (low_idx)
  );

  always_comb begin
    blocked = '0;
`ifdef IRQ_NESTING_EN
    // Only strictly higher priority than the best in-service IRQ may preempt.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (low_vld && IW'(i) >= low_idx) blocked[i] = 1'b1;
    end
    if (depth == ND_W'(NEST_DEPTH)) blocked = '1;
`else
    if (depth != '0) blocked = '1;
`endif
  end

  assign eligible = bus.irq_req & mask & ~blocked;
  assign reti_ok  = bus.reti && (depth != '0);
  assign svc_clr  = (bus.reti && low_vld)
                  ? NUM_IRQ'(1) << low_idx : '0;
  assign sel_idx  = (state == IDLE) ? win_idx : idx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (win_vld) state_nx = bus.skip ? SAVE : WAIT;
      WAIT: state_nx = SAVE;
      SAVE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mask   <= '0;
      in_svc <= '0;
      depth  <= '0;
      idx    <= '0;
      vaddr  <= '0;
      pc_int <= 1'b0;
      ack_q  <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.irq_mask_we) mask <= bus.irq_mask_wdata;
      // ack_q is non-zero exactly during SAVE
      in_svc <= (in_svc & ~svc_clr) | ack_q;
      depth  <= depth + ND_W'(|ack_q) - ND_W'(reti_ok);
      if (bus.reti && depth == '0) err <= 1'b1;
      if (state == IDLE && win_vld) begin
        idx   <= win_idx;
        vaddr <= ADDR_W'(vec_addr(VEC_BASE, VEC_STRIDE,
                                  32'(win_idx)));
      end
      pc_int <= (state_nx == SAVE);
      ack_q  <= (state_nx == SAVE)
              ? NUM_IRQ'(1) << sel_idx : '0;
    end
  end

  assign bus.pc_interrupt = pc_int;
  assign bus.vector_addr  = vaddr;
  assign bus.irq_ack      = ack_q;
  assign bus.in_service   = in_svc;
  assign bus.nest_depth   = depth;
  assign bus.busy         = (state != IDLE);
  assign bus.nest_error   = err;

endmodule

// File: tb/tb_pc_interrupt_sequencer.sv
// Self-checking bench for pc_interrupt_sequencer.
// Directed literal cases plus randomized traffic against a countdown model.
module tb_pc_interrupt_sequencer;
  import pc_seq_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned ND = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  pc_interrupt_sequencer_if #(
    .NUM_IRQ(N), .ADDR_W(AW), .NEST_DEPTH(ND)
  ) bus ();

  pc_interrupt_sequencer #(
    .NUM_IRQ(N), .ADDR_W(AW),
    .VEC_BASE(4), .VEC_STRIDE(4),
    .NEST_DEPTH(ND)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: m_left = cycles of the current sequence still to run,
  // including this one (pulse is due when it reads 1).
  bit [N-1:0] m_mask, m_isvc;
  int         m_left, m_idx;
  bit         m_err;

  function automatic void m_clear();
    m_mask = '0; m_isvc = '0;
    m_left = 0; m_idx = 0; m_err = 1'b0;
  endfunction

  function automatic int lowest(bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  function automatic void m_step();
    int         cnt, lo, w;
    bit [N-1:0] el;
    if (!reset) begin
      m_clear();
      return;
    end
    cnt = $countones(m_isvc);
    lo  = lowest(m_isvc);
    el  = '0;
    for (int i = 0; i < N; i++) begin
      bit ok;
      if (NESTING) ok = (cnt < ND) && (i < lo);
      else         ok = (cnt == 0);
      el[i] = bus.irq_req[i] & m_mask[i] & ok;
    end
    if (bus.reti) begin
      if (cnt == 0) m_err = 1'b1;
      else          m_isvc[lo] = 1'b0;
    end
    if (m_left == 1) m_isvc[m_idx] = 1'b1;
    if (m_left == 0) begin
      w = lowest(el);
      if (w < N) begin
        m_idx  = w;
        m_left = bus.skip ? 1 : 2;
      end
    end else begin
      m_left = m_left - 1;
    end
    if (bus.irq_mask_we) m_mask = bus.irq_mask_wdata;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit pc;
    pc = (m_left == 1);
    chk("pc_interrupt", int'(bus.pc_interrupt), int'(pc));
    chk("irq_ack", int'(bus.irq_ack),
        pc ? (1 << m_idx) : 0);
    if (pc)
      chk("vector_addr", int'(bus.vector_addr),
          (4 + 4 * m_idx) % 4096);
    chk("in_service", int'(bus.in_service), int'(m_isvc));
    chk("nest_depth", int'(bus.nest_depth),
        $countones(m_isvc));
    chk("busy", int'(bus.busy), int'(m_left != 0));
    chk("nest_error", int'(bus.nest_error), int'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycn(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_pulse(string nm, int exp_va);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc();
      if (bus.pc_interrupt) seen = 1'b1;
    end
    chk({nm, "_seen"}, int'(seen), 1);
    if (seen) chk({nm, "_vec"}, int'(bus.vector_addr), exp_va);
  endtask

  task automatic do_reti();
    bus.reti = 1'b1;
    cyc();
    bus.reti = 1'b0;
  endtask

  initial begin
    m_clear();
    bus.irq_req = '0;
    bus.irq_mask_we = 1'b0;
    bus.irq_mask_wdata = '0;
    bus.skip = 1'b0;
    bus.reti = 1'b0;
    cycn(2);
    chk("rst_vector", int'(bus.vector_addr), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b1;
    cyc();

    bus.irq_mask_we = 1'b1;
    bus.irq_mask_wdata = 4'b1111;
    cyc();
    bus.irq_mask_we = 1'b0;

    // normal path: pulse two cycles after acceptance
    bus.irq_req = 4'b0100;
    cyc();
    bus.irq_req = '0;
    chk("t1_wait_pc", int'(bus.pc_interrupt), 0);
    cyc();
    chk("t1_pc", int'(bus.pc_interrupt), 1);
    chk("t1_vec", int'(bus.vector_addr), 12);
    chk("t1_ack", int'(bus.irq_ack), 4'b0100);
    cyc();
    chk("t1_isvc", int'(bus.in_service), 4'b0100);
    chk("t1_depth", int'(bus.nest_depth), 1);
    do_reti();
    chk("t1_reti", int'(bus.in_service), 0);

    // skip path: pulse one cycle after acceptance
    bus.irq_req = 4'b0100;
    bus.skip = 1'b1;
    cyc();
    bus.irq_req = '0;
    bus.skip = 1'b0;
    chk("t2_pc", int'(bus.pc_interrupt), 1);
    chk("t2_vec", int'(bus.vector_addr), 12);
    cyc();
    do_reti();

    // simultaneous requests: 1 before 3
    bus.irq_req = 4'b1010;
    cycn(2);
    chk("t3_pc", int'(bus.pc_interrupt), 1);
    chk("t3_vec", int'(bus.vector_addr), 8);
    chk("t3_ack", int'(bus.irq_ack), 4'b0010);
    bus.irq_req = 4'b1000;
    cyc();
    chk("t3_isvc", int'(bus.in_service), 4'b0010);
    cycn(2);
    chk("t3_held", int'(bus.busy), 0);
    do_reti();
    wait_pulse("t3_irq3", 16);
    bus.irq_req = '0;
    cyc();
    do_reti();
    cyc();

    // higher priority while IRQ 2 in service
    bus.irq_req = 4'b0100;
    cyc();
    bus.irq_req = '0;
    cycn(2);
    bus.irq_req = 4'b0001;
`ifdef IRQ_NESTING_EN
    wait_pulse("t4_nest", 4);
    bus.irq_req = '0;
    cyc();
    chk("t4_isvc", int'(bus.in_service), 4'b0101);
    chk("t4_depth", int'(bus.nest_depth), 2);
    do_reti();
    do_reti();
`else
    cycn(4);
    chk("t4_isvc", int'(bus.in_service), 4'b0100);
    chk("t4_busy", int'(bus.busy), 0);
    do_reti();
    wait_pulse("t4_after", 4);
    bus.irq_req = '0;
    cyc();
    do_reti();
`endif
    chk("t4_empty", int'(bus.in_service), 0);

    // reti with nothing in service
    do_reti();
    chk("t5_err", int'(bus.nest_error), 1);
    chk("t5_isvc", int'(bus.in_service), 0);
    cyc();
    chk("t5_sticky", int'(bus.nest_error), 1);

    // reset during WAIT aborts the sequence
    bus.irq_req = 4'b0100;
    cyc();
    bus.irq_req = '0;
    chk("t6_busy_pre", int'(bus.busy), 1);
    reset = 1'b0;
    #1;
    chk("t6_busy_rst", int'(bus.busy), 0);
    chk("t6_err_rst", int'(bus.nest_error), 0);
    m_clear();
    cycn(2);
    reset = 1'b1;
    cycn(4);
    bus.irq_req = 4'b1111;
    cycn(4);
    chk("t6_masked", int'(bus.busy), 0);
    bus.irq_req = '0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 249) != 0);
      bus.irq_req = ($urandom_range(0, 2) == 0)
                  ? N'($urandom) : '0;
      bus.irq_mask_we = ($urandom_range(0, 19) == 0);
      bus.irq_mask_wdata = N'($urandom);
      bus.skip = ($urandom_range(0, 2) == 0);
      bus.reti = ($urandom_range(0, 5) == 0);
      cyc();
    end
    reset = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
